// File: rtl/sigdel_mod.sv
// sigdel_mod: second-order 1-bit sigma-delta modulator for offset-binary PCM.
//
// Each accepted sample is modulated for OSR clock cycles. Two sample slots sit
// in front of the loop: ACTIVE (being modulated) and NEXT (queued). At the end
// of every period NEXT is promoted into ACTIVE. If NEXT is empty at that point,
// ACTIVE is held and the sticky underrun flag is raised.
//
// Handshake: a sample transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready depends only on registered state
// (NEXT empty), so it never depends combinationally on in_valid.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         modulator enable (IDLE -> RUN needs en and a loaded ACTIVE)
//   in_sample  BITLEN-bit offset-binary PCM sample
//   in_valid   in_sample is valid this cycle
//   in_ready   block accepts in_sample this cycle
//   dout       registered 1-bit bitstream
//   underrun   sticky: a period ended with no sample queued
//   state_dbg  current FSM state (0 = IDLE, 1 = RUN)
module sigdel_mod #(
    parameter int BITLEN = 16,
    parameter int OSR    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [BITLEN-1:0] in_sample,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              dout,
    output logic              underrun,
    output logic              state_dbg
);

    localparam int W  = BITLEN + 4;
    localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(OSR - 1);

    // Integrator clamp limits and feedback magnitude, held one bit wider than
    // the integrators so the pre-saturation sums cannot wrap.
    localparam logic signed [W:0] SAT_MAX = (W+1)'((64'sd1 <<< (BITLEN + 2)) - 64'sd1);
    localparam logic signed [W:0] SAT_MIN = (W+1)'(-(64'sd1 <<< (BITLEN + 2)));
    localparam logic signed [W:0] FB_MAG  = (W+1)'(64'sd1 <<< (BITLEN - 1));

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q;
    logic [BITLEN-1:0]   active_q;
    logic [BITLEN-1:0]   next_q;
    logic                active_full;
    logic                next_full;
    logic [PW-1:0]       phase_q;
    logic signed [W-1:0] i1;
    logic signed [W-1:0] i2;
    logic                dout_q;
    logic                underrun_q;

    logic                accept;
    logic                run_step;
    logic                period_end;
    logic signed [BITLEN-1:0] x;
    logic signed [W:0]   fb;
    logic signed [W:0]   i1_sum;
    logic signed [W:0]   i2_sum;
    logic signed [W-1:0] i1_nxt;
    logic signed [W-1:0] i2_nxt;

    function automatic logic signed [W-1:0] sat(input logic signed [W:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[W-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[W-1:0];
        end else begin
            return v[W-1:0];
        end
    endfunction

    assign in_ready   = ~next_full;
    assign accept     = in_valid & ~next_full;
    assign run_step   = (state_q == RUN) && en;
    assign period_end = run_step && (phase_q == PHASE_LAST);

    // Offset binary -> two's complement is just an MSB flip.
    assign x  = {~active_q[BITLEN-1], active_q[BITLEN-2:0]};
    assign fb = dout_q ? FB_MAG : -FB_MAG;

    always_comb begin
        i1_sum = $signed({i1[W-1], i1})
               + $signed({{(W + 1 - BITLEN){x[BITLEN-1]}}, x}) - fb;
        // The second integrator consumes the first integrator's old value.
        i2_sum = $signed({i2[W-1], i2}) + $signed({i1[W-1], i1}) - fb;
        i1_nxt = sat(i1_sum);
        i2_nxt = sat(i2_sum);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            active_q    <= '0;
            next_q      <= '0;
            active_full <= 1'b0;
            next_full   <= 1'b0;
            phase_q     <= '0;
            i1          <= '0;
            i2          <= '0;
            dout_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            // Period boundary: promote NEXT, or flag the missing sample.
            if (period_end) begin
                if (next_full) begin
                    active_q  <= next_q;
                    next_full <= 1'b0;
                end else begin
                    underrun_q <= 1'b1;
                end
            end

            // An accept only happens while NEXT is empty, so it never collides
            // with the promotion above. ACTIVE is empty only before the first
            // sample after reset; once loaded it stays loaded.
            if (accept) begin
                if (!active_full) begin
                    active_q    <= in_sample;
                    active_full <= 1'b1;
                end else begin
                    next_q    <= in_sample;
                    next_full <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    i1      <= '0;
                    i2      <= '0;
                    phase_q <= '0;
                    dout_q  <= 1'b0;
                    if (en && active_full) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state_q <= IDLE;
                        i1      <= '0;
                        i2      <= '0;
                        phase_q <= '0;
                        dout_q  <= 1'b0;
                    end else begin
                        i1      <= i1_nxt;
                        i2      <= i2_nxt;
                        dout_q  <= ~i2_nxt[W-1];
                        phase_q <= period_end ? '0 : phase_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dout      = dout_q;
    assign underrun  = underrun_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sigdel_mod.sv
// tb_sigdel_mod: self-checking bench for sigdel_mod (BITLEN=16, OSR=4).
// A behavioural model (integer arithmetic, sample queue) predicts dout,
// in_ready, underrun and the FSM state every cycle; scenario tasks add
// density and handshake checks with hand-derived expectations.
module tb_sigdel_mod;

    localparam int B   = 16;
    localparam int OSR = 4;
    localparam longint HALF  = 64'sd1 <<< (B - 1);
    localparam longint I_MAX = (64'sd1 <<< (B + 2)) - 1;
    localparam longint I_MIN = -(64'sd1 <<< (B + 2));

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         in_valid = 1'b0;
    logic [B-1:0] in_sample = '0;
    logic         in_ready;
    logic         dout;
    logic         underrun;
    logic         state_dbg;

    int vectors = 0;
    int errors  = 0;

    // Reference model state. exp_q holds the loaded samples: [0] = ACTIVE,
    // [1] = NEXT (when present).
    logic [B-1:0] exp_q[$];
    longint m_i1 = 0;
    longint m_i2 = 0;
    int     m_phase = 0;
    bit     m_dout = 0;
    bit     m_under = 0;
    bit     m_run = 0;

    logic [3:0] exp_v;
    logic [3:0] obs_v;

    sigdel_mod #(.BITLEN(B), .OSR(OSR)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_sample (in_sample),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .underrun  (underrun),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic longint clamp(input longint v);
        if (v > I_MAX) return I_MAX;
        if (v < I_MIN) return I_MIN;
        return v;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        bit     acc;
        longint xv, fbv, n1, n2;
        if (rst) begin
            exp_q.delete();
            m_run = 0; m_i1 = 0; m_i2 = 0; m_phase = 0; m_dout = 0; m_under = 0;
            return;
        end
        acc = in_valid && (exp_q.size() < 2);
        if (!m_run) begin
            if (en && exp_q.size() > 0) m_run = 1;
        end else if (!en) begin
            m_run = 0; m_i1 = 0; m_i2 = 0; m_phase = 0; m_dout = 0;
        end else begin
            xv  = longint'(exp_q[0]) - HALF;
            fbv = m_dout ? HALF : -HALF;
            n1  = clamp(m_i1 + xv - fbv);
            n2  = clamp(m_i2 + m_i1 - fbv);
            m_i1 = n1;
            m_i2 = n2;
            m_dout = (n2 >= 0);
            if (m_phase == OSR - 1) begin
                m_phase = 0;
                if (exp_q.size() == 2) void'(exp_q.pop_front());
                else m_under = 1;
            end else begin
                m_phase++;
            end
        end
        if (acc) exp_q.push_back(in_sample);
    endtask

    // Inputs are driven around the falling edge; outputs are sampled at the
    // falling edge after each rising edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        exp_v = {m_dout, (exp_q.size() < 2), m_under, m_run};
        obs_v = {dout, in_ready, underrun, state_dbg};
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; in_valid = 1'b1; in_sample = 16'h1234;
        tick();
        vectors++;
        if (obs_v !== 4'b0100) begin
            errors++;
            $display("FAIL reset: {dout,in_ready,underrun,state}=%b expected 0100", obs_v);
        end
        rst = 1'b0; en = 1'b0; in_valid = 1'b0;
        tick();
        vectors++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL reset_idle: got %b expected %b", obs_v, exp_v);
        end
    endtask

    task automatic test_density(input logic [B-1:0] smp, input int lo, input int hi,
                                input bit chk_bounds);
        int ones;
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; in_valid = 1'b1; in_sample = smp;
        ones = 0;
        for (int c = 0; c < 64 + 1024; c++) begin
            tick();
            vectors++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL density_%h cycle %0d: got %b expected %b", smp, c, obs_v, exp_v);
            end
            if (c >= 64 && dout === 1'b1) ones++;
            if (chk_bounds) begin
                vectors++;
                if ($signed(dut.i1) > I_MAX || $signed(dut.i1) < I_MIN ||
                    $signed(dut.i2) > I_MAX || $signed(dut.i2) < I_MIN) begin
                    errors++;
                    $display("FAIL int_bounds cycle %0d: i1=%0d i2=%0d limits %0d..%0d",
                             c, $signed(dut.i1), $signed(dut.i2), I_MIN, I_MAX);
                end
            end
        end
        vectors++;
        if (ones < lo || ones > hi) begin
            errors++;
            $display("FAIL ones_%h: got %0d expected %0d..%0d", smp, ones, lo, hi);
        end
        vectors++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_%h: got %b expected 0", smp, underrun);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_underrun();
        int ones;
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; in_valid = 1'b1; in_sample = 16'h8000;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ur_ready: got %b expected 1", in_ready);
        end
        // k=1 enters RUN, k=2..5 are phases 0..3; the flag shows after k=5.
        for (int k = 1; k <= 5; k++) begin
            tick();
            vectors++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL ur_model k=%0d: got %b expected %b", k, obs_v, exp_v);
            end
            vectors++;
            if (underrun !== (k == 5)) begin
                errors++;
                $display("FAIL ur_flag k=%0d: got %b expected %b", k, underrun, (k == 5));
            end
        end
        ones = 0;
        for (int c = 0; c < 64; c++) begin
            tick();
            vectors++;
            if (obs_v !== exp_v || underrun !== 1'b1) begin
                errors++;
                $display("FAIL ur_hold cycle %0d: got %b expected %b", c, obs_v, exp_v);
            end
            if (dout === 1'b1) ones++;
        end
        vectors++;
        if (ones < 28 || ones > 36) begin
            errors++;
            $display("FAIL ur_density: got %0d ones expected 28..36", ones);
        end
    endtask

    task automatic test_back_to_back();
        int budget;
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; in_valid = 1'b1; in_sample = 16'($urandom);
        budget = 0;
        tick();
        while (!(m_run && m_phase == OSR - 1 && exp_q.size() == 2) && budget < 20) begin
            vectors++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL b2b_fill: got %b expected %b", obs_v, exp_v);
            end
            in_sample = 16'($urandom);
            tick();
            budget++;
        end
        vectors++;
        if (budget >= 20) begin
            errors++;
            $display("FAIL b2b_timeout: got no full last phase within %0d cycles", budget);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_last_phase: in_ready=%b expected 0", in_ready);
        end
        in_sample = 16'($urandom);
        tick();
        vectors++;
        if (in_ready !== 1'b1 || obs_v !== exp_v) begin
            errors++;
            $display("FAIL b2b_after_swap: in_ready=%b got %b expected 1/%b", in_ready, obs_v, exp_v);
        end
        tick();
        vectors++;
        if (in_ready !== 1'b0 || obs_v !== exp_v) begin
            errors++;
            $display("FAIL b2b_accept: in_ready=%b got %b expected 0/%b", in_ready, obs_v, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        // Entered from test_back_to_back: RUN with both slots full.
        rst = 1'b1; in_valid = 1'b1; in_sample = 16'hABCD;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        vectors++;
        if (obs_v !== 4'b0100) begin
            errors++;
            $display("FAIL rst_mid: {dout,in_ready,underrun,state}=%b expected 0100", obs_v);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            vectors++;
            if (obs_v !== 4'b0100) begin
                errors++;
                $display("FAIL rst_mid_idle cycle %0d: got %b expected 0100", c, obs_v);
            end
        end
        in_valid = 1'b1; in_sample = 16'h8000;
        tick();
        in_valid = 1'b0;
        tick();
        vectors++;
        if (state_dbg !== 1'b1 || obs_v !== exp_v) begin
            errors++;
            $display("FAIL rst_mid_restart: state=%b got %b expected 1/%b", state_dbg, obs_v, exp_v);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            en        = ($urandom_range(0, 15) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_sample = 16'($urandom);
            tick();
            vectors++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL random cycle %0d: got %b expected %b", c, obs_v, exp_v);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_density(16'h8000, 508, 516, 1'b0);
        test_density(16'hFFFF, 1016, 1024, 1'b1);
        test_density(16'h0000, 0, 8, 1'b0);
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/sigdel_mod.md
SIGDEL_MOD -- requirements
Module: sigdel_mod

Interface
REQ-001 SHALL have parameter BITLEN, default 16: width of the input PCM sample.
REQ-002 SHALL have parameter OSR, default 64: clock cycles each accepted sample is modulated; legal range 2..65535.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1: modulator enable.
REQ-006 SHALL have port in_sample, input, BITLEN: unsigned offset-binary PCM sample; 0 is negative full scale, 2^(BITLEN-1) is mid-scale.
REQ-007 SHALL have port in_valid, input, 1: in_sample is valid this cycle.
REQ-008 SHALL have port in_ready, output, 1: block accepts in_sample this cycle.
REQ-009 SHALL have port dout, output, 1: registered 1-bit sigma-delta bitstream.
REQ-010 SHALL have port underrun, output, 1: sticky flag; a period ended with no sample queued.

Function
REQ-011 SHALL transfer a sample only when in_valid and in_ready are both high at a rising clk edge.
REQ-012 SHALL hold two registers, ACTIVE (being modulated) and NEXT (queued), each with a full flag.
REQ-013 SHALL drive in_ready = not NEXT_full, combinationally from registered state only.
REQ-014 SHALL load an accepted sample into ACTIVE when ACTIVE is empty, otherwise into NEXT.
REQ-015 SHALL count OSR cycles per period in a phase counter 0..OSR-1 while in RUN, wrapping at OSR-1.
REQ-016 At phase OSR-1 with NEXT full, SHALL move NEXT to ACTIVE and clear NEXT_full in the same cycle; an accept in that cycle lands in NEXT.
REQ-017 At phase OSR-1 with NEXT empty, SHALL keep ACTIVE unchanged and set underrun; underrun clears only on rst.
REQ-018 SHALL convert ACTIVE to signed x by inverting its MSB (two's complement, BITLEN bits).
REQ-019 SHALL implement a second-order loop with signed integrators i1, i2 of width BITLEN+4 and feedback fb = +2^(BITLEN-1) when dout=1, else -2^(BITLEN-1).
REQ-020 Each RUN cycle: i1 <= sat(i1 + x - fb); i2 <= sat(i2 + i1_old - fb); dout <= (i2 new value >= 0).
REQ-021 sat() SHALL clamp to the range -2^(BITLEN+2) .. +2^(BITLEN+2)-1, with no wrap-around.
REQ-022 SHALL have states IDLE and RUN.
REQ-023 IDLE -> RUN when en=1 and ACTIVE_full=1.
REQ-024 RUN -> IDLE when en=0.
REQ-025 In IDLE: i1=i2=0, phase=0, dout=0, and queued samples are retained; in_ready continues to follow REQ-013.
REQ-026 Latency: the first RUN cycle updates dout on the following edge, i.e. one cycle after entering RUN.

Reset
REQ-027 On rst=1, SHALL set state=IDLE, i1=i2=0, phase=0, ACTIVE_full=NEXT_full=0, dout=0 and underrun=0, so in_ready=1 in the next cycle.
REQ-028 rst mid-operation SHALL discard both queued samples, and an accept in the same cycle as rst SHALL be ignored.
REQ-029 rst SHALL take priority over every other event.

Verification
REQ-030 Bench: rst, en=1, constant in_sample=0x8000 with in_valid held high for 1024 cycles -> count of dout ones in cycles 64..1087 is 512+/-4; underrun=0.
REQ-031 Bench: constant 0xFFFF for 1024 cycles -> at least 1016 ones; integrators never exceed the REQ-021 bounds.
REQ-032 Bench: constant 0x0000 -> at most 8 ones per 1024 cycles.
REQ-033 Bench: OSR=4, one sample 0x8000 then in_valid=0 -> in_ready returns high after 1 cycle; underrun=1 on the cycle after phase 3; dout continues unchanged in density.
REQ-034 Bench: ACTIVE and NEXT full, in_valid=1 at phase OSR-1 -> in_ready=0 that cycle; next cycle in_ready=1; the sample is accepted into NEXT one cycle later.
REQ-035 Bench: rst asserted in RUN with both slots full -> next cycle dout=0, underrun=0, in_ready=1, and state is IDLE until a new sample and en=1.
